// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep controller.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE
    } tt_state_t;

    localparam int TT_ROWS  = 16;
    localparam int TT_IDX_W = 4;

    // Row idx of a signature lives at bit (15 - idx): row 0 is the MSB.
    function automatic logic tt_exp_bit(input logic [TT_ROWS-1:0] tt, input logic [TT_IDX_W-1:0] idx);
        return tt[4'd15 - idx];
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times the settle window of each row.
module tt_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    // Loaded with N-1 so that expire is seen in the N-th settle cycle.
    localparam logic [7:0] LOAD_VAL = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == 8'd0);

endmodule

// File: rtl/tt_sweep_controller.sv
// Sweeps all 16 rows of a 4-input gate, builds its truth-table signature and checks it.
// Optional TT_ERRCNT_EN adds the err_cnt port counting rows that differ from EXPECTED_TT.
module tt_sweep_controller
    import tt_sweep_pkg::*;
#(
    parameter int              SETTLE_CYCLES = 2,
    parameter logic [15:0]     EXPECTED_TT   = 16'hD4E4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 dut_out,
    output logic [TT_IDX_W-1:0]  dut_in,
    output logic                 busy,
    output logic                 done,
    output logic [TT_ROWS-1:0]   tt_sig,
    output logic                 pass
`ifdef TT_ERRCNT_EN
    ,
    output logic [4:0]           err_cnt
`endif
);

    // With no settle window each row goes straight to its sample cycle.
    localparam tt_state_t ROW_ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    tt_state_t             state_q, state_d;
    logic [TT_IDX_W-1:0]   row_q, row_d;
    logic [TT_ROWS-1:0]    sh_q, sh_d;
    logic [TT_ROWS-1:0]    sh_shift;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [TT_ROWS-1:0]    tt_sig_q, tt_sig_d;
    logic                  pass_q, pass_d;
    logic                  timer_load, timer_en, timer_expire;
    logic                  accept, sample_fire, last_row;

    tt_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .en     (timer_en),
        .expire (timer_expire)
    );

    // A start coinciding with the done pulse is dropped; the host must re-issue it.
    assign accept      = (state_q == IDLE) && start && !done_q;
    assign sample_fire = (state_q == SAMPLE) && !abort;
    assign last_row    = (row_q == 4'd15);
    assign sh_shift    = {sh_q[TT_ROWS-2:0], dut_out};

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        sh_d       = sh_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tt_sig_d   = tt_sig_q;
        pass_d     = pass_q;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    row_d      = '0;
                    sh_d       = '0;
                    busy_d     = 1'b1;
                    timer_load = 1'b1;
                    state_d    = ROW_ENTRY;
                end
            end
            SETTLE: begin
                timer_en = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    row_d   = '0;
                end else if (timer_expire) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    row_d   = '0;
                end else begin
                    sh_d = sh_shift;
                    if (last_row) begin
                        tt_sig_d = sh_shift;
                        pass_d   = (sh_shift == EXPECTED_TT);
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        row_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        row_d      = row_q + 4'd1;
                        timer_load = 1'b1;
                        state_d    = ROW_ENTRY;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                row_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            sh_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tt_sig_q <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            sh_q     <= sh_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tt_sig_q <= tt_sig_d;
            pass_q   <= pass_d;
        end
    end

    assign dut_in = row_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign tt_sig = tt_sig_q;
    assign pass   = pass_q;

`ifdef TT_ERRCNT_EN
    logic [4:0] errc_q, errc_d;
    logic [4:0] err_cnt_q, err_cnt_d;
    logic       row_mismatch;

    assign row_mismatch = (dut_out != tt_exp_bit(EXPECTED_TT, row_q));

    // Running count lives in errc; the visible copy only moves with tt_sig at done.
    always_comb begin
        errc_d    = errc_q;
        err_cnt_d = err_cnt_q;
        if (accept) begin
            errc_d = 5'd0;
        end else if (sample_fire) begin
            errc_d = errc_q + {4'd0, row_mismatch};
            if (last_row) begin
                err_cnt_d = errc_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errc_q    <= 5'd0;
            err_cnt_q <= 5'd0;
        end else begin
            errc_q    <= errc_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_tt_sweep_controller.sv
// Self-checking bench for tt_sweep_controller: SETTLE_CYCLES=2 and SETTLE_CYCLES=0 instances.
module tb_tt_sweep_controller;

    typedef struct {
        logic [15:0] tt;
        logic        pass;
        logic [4:0]  ec;
    } exp_t;

    localparam logic [15:0] GOLDEN = 16'hD4E4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, abort_a, dut_out_a, busy_a, done_a, pass_a;
    logic [3:0]  dut_in_a;
    logic [15:0] tt_sig_a;
    logic        start_b, abort_b, dut_out_b, busy_b, done_b, pass_b;
    logic [3:0]  dut_in_b;
    logic [15:0] tt_sig_b;
    int          mode_a, mode_b;
    int          n_pass, n_total;
    exp_t        sb_q[$];
`ifdef TT_ERRCNT_EN
    logic [4:0]  err_cnt_a, err_cnt_b;
`endif

    always #5 clk = ~clk;

    // Gate model: 0 = golden NOR/NOT netlist, 1 = stuck at 0, 2 = stuck at 1.
    function automatic logic model_out(input int mode, input logic [3:0] row);
        logic [15:0] g;
        g = GOLDEN;
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            default: return g[4'd15 - row];
        endcase
    endfunction

    assign dut_out_a = model_out(mode_a, dut_in_a);
    assign dut_out_b = model_out(mode_b, dut_in_b);

    tt_sweep_controller #(.SETTLE_CYCLES(2), .EXPECTED_TT(GOLDEN)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .dut_out(dut_out_a),
        .dut_in(dut_in_a), .busy(busy_a), .done(done_a), .tt_sig(tt_sig_a), .pass(pass_a)
`ifdef TT_ERRCNT_EN
        , .err_cnt(err_cnt_a)
`endif
    );

    tt_sweep_controller #(.SETTLE_CYCLES(0), .EXPECTED_TT(GOLDEN)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .dut_out(dut_out_b),
        .dut_in(dut_in_b), .busy(busy_b), .done(done_b), .tt_sig(tt_sig_b), .pass(pass_b)
`ifdef TT_ERRCNT_EN
        , .err_cnt(err_cnt_b)
`endif
    );

    task automatic push_expected(input int mode);
        exp_t e;
        e.tt = '0;
        e.ec = '0;
        for (int r = 0; r < 16; r++) begin
            e.tt[15-r] = model_out(mode, 4'(r));
        end
        for (int b = 0; b < 16; b++) begin
            if (e.tt[b] != GOLDEN[b]) e.ec = e.ec + 5'd1;
        end
        e.pass = (e.tt == GOLDEN);
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        mode_a = 0; mode_b = 0;
        #1;
        n_total++;
        if ({dut_in_a, busy_a, done_a, tt_sig_a, pass_a} !== 23'd0)
            $display("FAIL reset_hold: got dut_in=%h busy=%b done=%b tt=%h pass=%b required all 0",
                     dut_in_a, busy_a, done_a, tt_sig_a, pass_a);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({dut_in_a, busy_a, done_a, tt_sig_a, pass_a} !== 23'd0)
            $display("FAIL reset_release: got busy=%b dut_in=%h required 0", busy_a, dut_in_a);
        else n_pass++;
        // Asynchronous reset in the middle of a sweep
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (9) @(negedge clk);
        n_total++;
        if (busy_a !== 1'b1 || dut_in_a !== 4'd3)
            $display("FAIL reset_presweep: got busy=%b dut_in=%h required 1/3", busy_a, dut_in_a);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({dut_in_a, busy_a, done_a, tt_sig_a, pass_a} !== 23'd0)
            $display("FAIL reset_midsweep: got dut_in=%h busy=%b done=%b required 0",
                     dut_in_a, busy_a, done_a);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) begin
            @(negedge clk);
            n_total++;
            if (done_a !== 1'b0 || busy_a !== 1'b0)
                $display("FAIL reset_no_done: got done=%b busy=%b required 0/0", done_a, busy_a);
            else n_pass++;
        end
        $display("reset test complete");
    endtask

    // Full sweep on the SETTLE_CYCLES=2 instance with cycle-exact timing checks.
    task automatic test_sweep(input int mode);
        exp_t e;
        mode_a = mode;
        push_expected(mode);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int m = 0; m < 48; m++) begin
            n_total++;
            if (dut_in_a !== 4'(m / 3) || busy_a !== 1'b1 || done_a !== 1'b0)
                $display("FAIL sweep_step%0d: got dut_in=%h busy=%b done=%b required %h/1/0",
                         m, dut_in_a, busy_a, done_a, 4'(m / 3));
            else n_pass++;
            @(negedge clk);
        end
        n_total++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || dut_in_a !== 4'd0)
            $display("FAIL sweep_done: got done=%b busy=%b dut_in=%h required 1/0/0",
                     done_a, busy_a, dut_in_a);
        else n_pass++;
        n_total++;
        if (sb_q.size() == 0) begin
            $display("FAIL sweep_sb: got empty scoreboard required one entry");
        end else begin
            n_pass++;
            e = sb_q.pop_front();
            n_total++;
            if (tt_sig_a !== e.tt || pass_a !== e.pass)
                $display("FAIL sweep_result: got tt=%h pass=%b required %h/%b",
                         tt_sig_a, pass_a, e.tt, e.pass);
            else n_pass++;
`ifdef TT_ERRCNT_EN
            n_total++;
            if (err_cnt_a !== e.ec)
                $display("FAIL sweep_errcnt: got %0d required %0d", err_cnt_a, e.ec);
            else n_pass++;
`endif
        end
        @(negedge clk);
        n_total++;
        if (done_a !== 1'b0)
            $display("FAIL sweep_done_pulse: got done=%b required 0", done_a);
        else n_pass++;
        $display("sweep mode=%0d tt_sig=%h pass=%b", mode, tt_sig_a, pass_a);
    endtask

    task automatic test_abort();
        int dones;
        test_sweep(0);
        mode_a = 2;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (15) @(negedge clk);
        n_total++;
        if (dut_in_a !== 4'd5)
            $display("FAIL abort_row: got dut_in=%h required 5", dut_in_a);
        else n_pass++;
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        n_total++;
        if (busy_a !== 1'b0 || dut_in_a !== 4'd0 || done_a !== 1'b0)
            $display("FAIL abort_idle: got busy=%b dut_in=%h done=%b required 0/0/0",
                     busy_a, dut_in_a, done_a);
        else n_pass++;
        n_total++;
        if (tt_sig_a !== GOLDEN || pass_a !== 1'b1)
            $display("FAIL abort_retain: got tt=%h pass=%b required %h/1", tt_sig_a, pass_a, GOLDEN);
        else n_pass++;
`ifdef TT_ERRCNT_EN
        n_total++;
        if (err_cnt_a !== 5'd0)
            $display("FAIL abort_errcnt: got %0d required 0", err_cnt_a);
        else n_pass++;
`endif
        dones = 0;
        repeat (60) begin
            @(negedge clk);
            if (done_a === 1'b1 || busy_a === 1'b1) dones++;
        end
        n_total++;
        if (dones != 0)
            $display("FAIL abort_no_done: got %0d done/busy cycles required 0", dones);
        else n_pass++;
        $display("abort at row 5 tt_sig=%h pass=%b", tt_sig_a, pass_a);
    endtask

    task automatic test_start_held();
        exp_t e;
        int   dones, done_at;
        logic busy_after [2];
        mode_a = 0;
        push_expected(0);
        dones = 0; done_at = -1;
        busy_after[0] = 1'bx; busy_after[1] = 1'bx;
        start_a = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == done_at + 1) busy_after[0] = busy_a;
            if (n == done_at + 2) busy_after[1] = busy_a;
            if (done_a === 1'b1) begin
                dones++;
                done_at = n;
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    n_total++;
                    if (tt_sig_a !== e.tt || pass_a !== e.pass)
                        $display("FAIL held_result: got tt=%h pass=%b required %h/%b",
                                 tt_sig_a, pass_a, e.tt, e.pass);
                    else n_pass++;
                end
            end
        end
        start_a = 1'b0;
        n_total++;
        if (dones != 1 || done_at != 49)
            $display("FAIL held_done: got %0d pulses at %0d required 1 at 49", dones, done_at);
        else n_pass++;
        n_total++;
        if (busy_after[0] !== 1'b0 || busy_after[1] !== 1'b1)
            $display("FAIL held_restart: got busy=%b,%b after done required 0,1",
                     busy_after[0], busy_after[1]);
        else n_pass++;
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        n_total++;
        if (busy_a !== 1'b0)
            $display("FAIL held_cleanup: got busy=%b required 0", busy_a);
        else n_pass++;
        $display("start held: %0d done pulse(s), first at cycle %0d", dones, done_at);
    endtask

    task automatic test_settle_zero();
        exp_t e;
        mode_b = 0;
        push_expected(0);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int m = 0; m < 16; m++) begin
            n_total++;
            if (dut_in_b !== 4'(m) || busy_b !== 1'b1 || done_b !== 1'b0)
                $display("FAIL zero_step%0d: got dut_in=%h busy=%b done=%b required %h/1/0",
                         m, dut_in_b, busy_b, done_b, 4'(m));
            else n_pass++;
            @(negedge clk);
        end
        n_total++;
        if (done_b !== 1'b1)
            $display("FAIL zero_done: got done=%b required 1", done_b);
        else n_pass++;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_total++;
            if (tt_sig_b !== e.tt || pass_b !== e.pass)
                $display("FAIL zero_result: got tt=%h pass=%b required %h/%b",
                         tt_sig_b, pass_b, e.tt, e.pass);
            else n_pass++;
`ifdef TT_ERRCNT_EN
            n_total++;
            if (err_cnt_b !== e.ec)
                $display("FAIL zero_errcnt: got %0d required %0d", err_cnt_b, e.ec);
            else n_pass++;
`endif
        end
        $display("settle=0 sweep tt_sig=%h pass=%b", tt_sig_b, pass_b);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_sweep(0);
        test_sweep(1);
        test_sweep(2);
        test_abort();
        test_start_held();
        test_settle_zero();
        n_total++;
        if (sb_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d entries left required 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
